// File: rtl/psram_pkg.sv
// -----------------------------------------------------------------------------
// psram_pkg
// Shared definitions for the QPI PSRAM responder:
//   - supported opcodes (quad read 0xEB, quad write 0x38)
//   - command/address phase lengths in nibbles
//   - responder FSM state encoding
//   - saturating 16-bit increment used by the optional statistics counters
// -----------------------------------------------------------------------------
package psram_pkg;

  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_QWRITE = 8'h38;

  localparam int CMD_NIBBLES  = 2;
  localparam int ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    WAIT   = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } psram_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/psram_sync_edge.sv
// -----------------------------------------------------------------------------
// psram_sync_edge
// Two-flop synchroniser for one asynchronous bus line, followed by a history
// flop that yields single-clk rise/fall pulses. A bus edge shows up as a
// pulse two clk edges after it is first captured, so logic acting on the
// pulse reacts on the third clk edge.
//
// Parameters:
//   RST_VAL  idle level of the line (reset value of all stages)
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   din      asynchronous input line
//   rise     one-clk pulse on a synchronised 0->1 transition
//   fall     one-clk pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module psram_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Metastability filter plus one stage of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      prev_r <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  // Pulses are decoded purely from flop outputs, so they are glitch-free.
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/psram_qspi_responder.sv
// -----------------------------------------------------------------------------
// psram_qspi_responder
// QPI (mode 0) PSRAM target backed by an on-chip byte array. The serial bus
// is oversampled in the clk domain: clk must run at least 4x SCK. The
// initiator changes data on SCK fall; this block samples on SCK rise and
// updates its read data on SCK fall. Nibbles travel MSB-first.
//
// Transaction: 2 opcode nibbles, 6 address nibbles, then
//   0xEB: WAIT_CYCLES dummy rises, then read data (address auto-increments)
//   0x38: write data (address auto-increments)
//   other: ignored until ce_n rises, cmd_err set (sticky until reset)
// The byte index is the address modulo MEM_BYTES and wraps at the top.
// Raising ce_n aborts any phase: output enable drops, a half-written byte
// is discarded.
//
// Optional build macro PSRAM_RESP_STATS_EN adds rd_bytes / wr_bytes,
// saturating counters of bytes completely sent / committed.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   psram_sck    bus serial clock (asynchronous)
//   psram_ce_n   bus chip enable, active-low (asynchronous)
//   psram_d_in   bus data from initiator (asynchronous)
//   psram_d_out  bus data to initiator
//   psram_d_oe   high while psram_d_out is driven
//   busy         high while the synchronised ce_n is low
//   rd_bytes     (PSRAM_RESP_STATS_EN) bytes sent
//   wr_bytes     (PSRAM_RESP_STATS_EN) bytes committed
//   cmd_err      sticky unsupported-opcode flag
// -----------------------------------------------------------------------------
module psram_qspi_responder
  import psram_pkg::*;
#(
  parameter int MEM_BYTES   = 64,
  parameter int ADDR_W      = 24,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       psram_sck,
  input  logic       psram_ce_n,
  input  logic [3:0] psram_d_in,
  output logic [3:0] psram_d_out,
  output logic       psram_d_oe,
  output logic       busy,
`ifdef PSRAM_RESP_STATS_EN
  output logic [15:0] rd_bytes,
  output logic [15:0] wr_bytes,
`endif
  output logic       cmd_err
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  // Address phase length follows ADDR_W but never drops below the bus format.
  localparam int ADDR_NIB = ((ADDR_W / 4) > ADDR_NIBBLES) ? (ADDR_W / 4) : ADDR_NIBBLES;

  localparam logic [7:0] CMD_LAST  = 8'(CMD_NIBBLES - 1);
  localparam logic [7:0] ADDR_LAST = 8'(ADDR_NIB - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic       sck_rise_s;
  logic       sck_fall_s;
  logic       ce_rise_s;
  logic       ce_fall_s;
  logic [3:0] d_meta_r;
  logic [3:0] d_sync_r;

  psram_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (psram_sck),
    .rise  (sck_rise_s),
    .fall  (sck_fall_s)
  );

  psram_sync_edge #(.RST_VAL(1'b1)) u_ce_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (psram_ce_n),
    .rise  (ce_rise_s),
    .fall  (ce_fall_s)
  );

  // Data bus synchroniser; it settles alongside the sck rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_meta_r <= 4'h0;
      d_sync_r <= 4'h0;
    end else begin
      d_meta_r <= psram_d_in;
      d_sync_r <= d_meta_r;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  psram_state_e     state_r;
  logic [7:0]       cnt_r;       // nibble / dummy-cycle counter within a phase
  logic [3:0]       op_hi_r;     // first opcode nibble
  logic             is_wr_r;     // opcode was a write
  logic [IDX_W-1:0] idx_r;       // current byte index (address shift reg in ADDR)
  logic [3:0]       temp_r;      // high nibble of a write byte in flight
  logic             lo_phase_r;  // next nibble is the low nibble of the byte
  logic             lo_sent_r;   // a low read nibble is on the bus, not yet sampled
  logic [3:0]       d_out_r;
  logic             d_oe_r;
  logic             busy_r;
  logic             cmd_err_r;
`ifdef PSRAM_RESP_STATS_EN
  logic [15:0]      rd_bytes_r;
  logic [15:0]      wr_bytes_r;
`endif

  logic [7:0]       mem_r [MEM_BYTES];
  logic [7:0]       rd_byte_s;
  logic [7:0]       opcode_s;
  logic             mem_we_s;
  logic [7:0]       mem_wdata_s;

  // Opcode, read-data and write-strobe decode from the current state.
  always_comb begin
    opcode_s    = {op_hi_r, d_sync_r};
    rd_byte_s   = mem_r[idx_r];
    mem_wdata_s = {temp_r, d_sync_r};
    mem_we_s    = 1'b0;
    // An aborting ce_n rise in the same clk suppresses the commit.
    if ((state_r == WDATA) && sck_rise_s && !ce_rise_s && lo_phase_r) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Backing store: no reset, written only on a completed byte.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_r] <= mem_wdata_s;
    end
  end

  // Responder FSM with its counters and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      op_hi_r    <= 4'h0;
      is_wr_r    <= 1'b0;
      idx_r      <= '0;
      temp_r     <= 4'h0;
      lo_phase_r <= 1'b0;
      lo_sent_r  <= 1'b0;
      d_out_r    <= 4'h0;
      d_oe_r     <= 1'b0;
      busy_r     <= 1'b0;
      cmd_err_r  <= 1'b0;
`ifdef PSRAM_RESP_STATS_EN
      rd_bytes_r <= 16'd0;
      wr_bytes_r <= 16'd0;
`endif
    end else if (ce_rise_s) begin
      // End of transaction wins over any sck edge seen in the same clk.
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      lo_phase_r <= 1'b0;
      lo_sent_r  <= 1'b0;
      d_out_r    <= 4'h0;
      d_oe_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ce_fall_s) begin
            state_r <= CMD;
            cnt_r   <= 8'd0;
            busy_r  <= 1'b1;
          end
        end

        CMD: begin
          if (sck_rise_s) begin
            if (cnt_r == CMD_LAST) begin
              cnt_r <= 8'd0;
              if (opcode_s == OP_QREAD) begin
                state_r <= ADDR;
                is_wr_r <= 1'b0;
              end else if (opcode_s == OP_QWRITE) begin
                state_r <= ADDR;
                is_wr_r <= 1'b1;
              end else begin
                state_r   <= IGNORE;
                cmd_err_r <= 1'b1;
              end
            end else begin
              op_hi_r <= d_sync_r;
              cnt_r   <= cnt_r + 8'd1;
            end
          end
        end

        ADDR: begin
          if (sck_rise_s) begin
            // Only the low IDX_W address bits survive: addr mod MEM_BYTES.
            idx_r <= IDX_W'({idx_r, d_sync_r});
            if (cnt_r == ADDR_LAST) begin
              cnt_r      <= 8'd0;
              lo_phase_r <= 1'b0;
              state_r    <= is_wr_r ? WDATA : WAIT;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
        end

        WAIT: begin
          if (sck_rise_s) begin
            if (cnt_r == WAIT_LAST) begin
              cnt_r      <= 8'd0;
              state_r    <= RDATA;
              d_oe_r     <= 1'b1;
              lo_phase_r <= 1'b0;
              lo_sent_r  <= 1'b0;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
        end

        RDATA: begin
          if (sck_fall_s) begin
            if (lo_phase_r) begin
              d_out_r    <= rd_byte_s[3:0];
              lo_phase_r <= 1'b0;
              lo_sent_r  <= 1'b1;
              idx_r      <= idx_r + IDX_ONE;
            end else begin
              d_out_r    <= rd_byte_s[7:4];
              lo_phase_r <= 1'b1;
            end
          end else if (sck_rise_s && lo_sent_r) begin
            // A byte counts as sent once the initiator has sampled its low nibble.
            lo_sent_r <= 1'b0;
`ifdef PSRAM_RESP_STATS_EN
            rd_bytes_r <= sat_inc16(rd_bytes_r);
`endif
          end
        end

        WDATA: begin
          if (sck_rise_s) begin
            if (lo_phase_r) begin
              lo_phase_r <= 1'b0;
              idx_r      <= idx_r + IDX_ONE;
`ifdef PSRAM_RESP_STATS_EN
              wr_bytes_r <= sat_inc16(wr_bytes_r);
`endif
            end else begin
              temp_r     <= d_sync_r;
              lo_phase_r <= 1'b1;
            end
          end
        end

        IGNORE: begin
          state_r <= IGNORE;
        end

        default: begin
          state_r <= IDLE;
          d_oe_r  <= 1'b0;
        end
      endcase
    end
  end

  assign psram_d_out = d_out_r;
  assign psram_d_oe  = d_oe_r;
  assign busy        = busy_r;
  assign cmd_err     = cmd_err_r;
`ifdef PSRAM_RESP_STATS_EN
  assign rd_bytes    = rd_bytes_r;
  assign wr_bytes    = wr_bytes_r;
`endif

endmodule

// File: tb/tb_psram_qspi_responder.sv
// -----------------------------------------------------------------------------
// tb_psram_qspi_responder
// Directed bench acting as a QPI PSRAM initiator. SCK half period is 4 clk.
// Build with PSRAM_RESP_STATS_EN defined to cover the statistics counters.
// -----------------------------------------------------------------------------
module tb_psram_qspi_responder;

  localparam int CLK  = 10;
  localparam int HALF = 40;
  localparam int WAIT_CYCLES = 6;

  logic       clk;
  logic       rst_n;
  logic       psram_sck;
  logic       psram_ce_n;
  logic [3:0] psram_d_in;
  logic [3:0] psram_d_out;
  logic       psram_d_oe;
  logic       busy;
  logic       cmd_err;
`ifdef PSRAM_RESP_STATS_EN
  logic [15:0] rd_bytes;
  logic [15:0] wr_bytes;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rd_buf [8];
  logic       oe_seen = 1'b0;

  psram_qspi_responder #(
    .MEM_BYTES   (64),
    .ADDR_W      (24),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .psram_sck   (psram_sck),
    .psram_ce_n  (psram_ce_n),
    .psram_d_in  (psram_d_in),
    .psram_d_out (psram_d_out),
    .psram_d_oe  (psram_d_oe),
    .busy        (busy),
`ifdef PSRAM_RESP_STATS_EN
    .rd_bytes    (rd_bytes),
    .wr_bytes    (wr_bytes),
`endif
    .cmd_err     (cmd_err)
  );

  initial clk = 1'b0;
  always #(CLK/2) clk = ~clk;

  always @(posedge clk) begin
    if (psram_d_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cs_start();
    @(negedge clk);
    psram_ce_n = 1'b0;
    #(2*HALF);
  endtask

  task automatic cs_stop();
    #(HALF);
    psram_ce_n = 1'b1;
    #(8*CLK);
  endtask

  task automatic send_nib(input logic [3:0] n);
    psram_d_in = n;
    #(HALF);
    psram_sck = 1'b1;
    #(HALF);
    psram_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
    cs_start();
    send_byte(op);
    for (int i = 5; i >= 0; i--) send_nib(addr[4*i +: 4]);
  endtask

  task automatic recv_nib(output logic [3:0] n);
    #(HALF);
    n = psram_d_out;
    chk("oe during read data", {31'd0, psram_d_oe}, 32'd1);
    psram_sck = 1'b1;
    #(HALF);
    psram_sck = 1'b0;
  endtask

  // Header plus dummy cycles; leaves the responder about to drive data.
  task automatic read_prologue(input logic [23:0] addr);
    send_hdr(8'hEB, addr);
    for (int i = 0; i < WAIT_CYCLES - 1; i++) send_nib(4'h0);
    chk("oe low before last dummy", {31'd0, psram_d_oe}, 32'd0);
    send_nib(4'h0);
  endtask

  task automatic psram_read(input logic [23:0] addr, input int n);
    logic [3:0] hi;
    logic [3:0] lo;
    read_prologue(addr);
    for (int i = 0; i < n; i++) begin
      recv_nib(hi);
      recv_nib(lo);
      rd_buf[i] = {hi, lo};
    end
    cs_stop();
    chk("oe low after read", {31'd0, psram_d_oe}, 32'd0);
  endtask

  // data holds n bytes, first byte in the most significant used position.
  task automatic psram_write(input logic [23:0] addr, input int n, input logic [63:0] data);
    send_hdr(8'h38, addr);
    chk("busy in write", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) send_byte(data[8*(n-1-i) +: 8]);
    cs_stop();
  endtask

  initial begin
    rst_n      = 1'b0;
    psram_sck  = 1'b0;
    psram_ce_n = 1'b1;
    psram_d_in = 4'h0;
    #(5*CLK);
    @(negedge clk);
    chk("reset d_oe", {31'd0, psram_d_oe}, 32'd0);
    chk("reset d_out", {28'd0, psram_d_out}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset cmd_err", {31'd0, cmd_err}, 32'd0);
    rst_n = 1'b1;
    #(5*CLK);

    // Write then read back.
    oe_seen = 1'b0;
    psram_write(24'h000010, 2, 64'hA53C);
    chk("no drive in write", {31'd0, oe_seen}, 32'd0);
    psram_read(24'h000010, 2);
    chk("rd 0x10", {24'd0, rd_buf[0]}, 32'hA5);
    chk("rd 0x11", {24'd0, rd_buf[1]}, 32'h3C);

    // Wrap at the top of the 64-byte array.
    psram_write(24'h00003F, 3, 64'h112233);
    psram_read(24'h00003F, 3);
    chk("wrap rd 0x3F", {24'd0, rd_buf[0]}, 32'h11);
    chk("wrap rd 0x00", {24'd0, rd_buf[1]}, 32'h22);
    chk("wrap rd 0x01", {24'd0, rd_buf[2]}, 32'h33);
    psram_read(24'h000000, 2);
    chk("direct rd 0x00", {24'd0, rd_buf[0]}, 32'h22);
    chk("direct rd 0x01", {24'd0, rd_buf[1]}, 32'h33);

    // Aborted write: one full byte then a dangling nibble.
    psram_write(24'h000020, 2, 64'h7777);
    send_hdr(8'h38, 24'h000020);
    send_nib(4'hA);
    send_nib(4'hB);
    send_nib(4'hC);
    #(HALF);
    @(negedge clk);
    psram_ce_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort idle busy", {31'd0, busy}, 32'd0);
    chk("abort d_oe", {31'd0, psram_d_oe}, 32'd0);
    #(8*CLK);
    psram_read(24'h000020, 2);
    chk("abort rd 0x20", {24'd0, rd_buf[0]}, 32'hAB);
    chk("abort rd 0x21", {24'd0, rd_buf[1]}, 32'h77);

    // Unsupported opcode followed by what would be a write to 0x10.
    oe_seen = 1'b0;
    cs_start();
    send_byte(8'h9F);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'hFF);
    cs_stop();
    chk("bad op no drive", {31'd0, oe_seen}, 32'd0);
    chk("bad op cmd_err", {31'd0, cmd_err}, 32'd1);
    psram_read(24'h000010, 2);
    chk("after bad rd 0x10", {24'd0, rd_buf[0]}, 32'hA5);
    chk("after bad rd 0x11", {24'd0, rd_buf[1]}, 32'h3C);
    chk("cmd_err sticky", {31'd0, cmd_err}, 32'd1);

    // Reset in the middle of a read.
    begin
      logic [3:0] nib;
      read_prologue(24'h000010);
      recv_nib(nib);
      chk("pre-reset nibble", {28'd0, nib}, 32'hA);
      #(2*CLK);
      rst_n = 1'b0;
      #1;
      chk("mid-reset d_oe", {31'd0, psram_d_oe}, 32'd0);
      chk("mid-reset busy", {31'd0, busy}, 32'd0);
      chk("mid-reset cmd_err", {31'd0, cmd_err}, 32'd0);
      psram_ce_n = 1'b1;
      psram_sck  = 1'b0;
      #(5*CLK);
      rst_n = 1'b1;
      #(5*CLK);
    end
`ifdef PSRAM_RESP_STATS_EN
    chk("stats rd reset", {16'd0, rd_bytes}, 32'd0);
    chk("stats wr reset", {16'd0, wr_bytes}, 32'd0);
`endif
    psram_read(24'h000010, 2);
    chk("post-reset rd 0x10", {24'd0, rd_buf[0]}, 32'hA5);
    chk("post-reset rd 0x11", {24'd0, rd_buf[1]}, 32'h3C);

`ifdef PSRAM_RESP_STATS_EN
    psram_write(24'h000028, 5, 64'h0102030405);
    chk("stats wr 5", {16'd0, wr_bytes}, 32'd5);
    psram_read(24'h000028, 3);
    chk("stats data 0", {24'd0, rd_buf[0]}, 32'h01);
    chk("stats data 2", {24'd0, rd_buf[2]}, 32'h03);
    chk("stats rd 2+3", {16'd0, rd_bytes}, 32'd5);
    begin
      logic [3:0] nib;
      read_prologue(24'h000028);
      recv_nib(nib);
      cs_stop();
      chk("interrupted nibble", {28'd0, nib}, 32'h0);
    end
    chk("stats rd after abort", {16'd0, rd_bytes}, 32'd5);
    chk("stats wr unchanged", {16'd0, wr_bytes}, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
